// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: parses opcode/address/data bytes of a chip-select frame
// into register writes and framebuffer writes (streamed data or hardware fill).
module spi_cmd_ctrl #(
    parameter int AW = 17
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          byteValid_i,
    input  logic [7:0]    byteIn_i,
    input  logic          frameActive_i,
    output logic          memReq_o,
    output logic [AW-1:0] memAddr_o,
    output logic [7:0]    memData_o,
    input  logic          memAck_i,
    output logic          regWe_o,
    output logic [7:0]    regAddr_o,
    output logic [7:0]    regData_o,
    output logic          busy_o,
    output logic          overrun_o
);

    typedef enum logic [3:0] {
        IDLE, ADDR, REGA, REGD, CNT, VAL, WDATA, FILL, SKIP, DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [1:0]    byteCnt_q, byteCnt_d;
    logic          isFill_q, isFill_d;
    logic [7:0]    fillVal_q, fillVal_d;
    logic          memReq_q, memReq_d;
    logic [AW-1:0] memAddr_q, memAddr_d;
    logic [7:0]    memData_q, memData_d;
    logic          holdValid_q, holdValid_d;
    logic [7:0]    holdData_q, holdData_d;
    logic          regWe_q, regWe_d;
    logic [7:0]    regAddr_q, regAddr_d;
    logic [7:0]    regData_q, regData_d;
    logic          overrun_q, overrun_d;

    logic          byteOk;
    logic          ack;
    logic [AW+7:0] shifted;

    assign byteOk  = byteValid_i && frameActive_i;
    assign ack     = memReq_q && memAck_i;
    // Upper address bits beyond AW fall off the top as bytes shift in.
    assign shifted = {addr_q, byteIn_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            byteCnt_q   <= '0;
            isFill_q    <= 1'b0;
            fillVal_q   <= '0;
            memReq_q    <= 1'b0;
            memAddr_q   <= '0;
            memData_q   <= '0;
            holdValid_q <= 1'b0;
            holdData_q  <= '0;
            regWe_q     <= 1'b0;
            regAddr_q   <= '0;
            regData_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            byteCnt_q   <= byteCnt_d;
            isFill_q    <= isFill_d;
            fillVal_q   <= fillVal_d;
            memReq_q    <= memReq_d;
            memAddr_q   <= memAddr_d;
            memData_q   <= memData_d;
            holdValid_q <= holdValid_d;
            holdData_q  <= holdData_d;
            regWe_q     <= regWe_d;
            regAddr_q   <= regAddr_d;
            regData_q   <= regData_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        byteCnt_d   = byteCnt_q;
        isFill_d    = isFill_q;
        fillVal_d   = fillVal_q;
        memReq_d    = memReq_q;
        memAddr_d   = memAddr_q;
        memData_d   = memData_q;
        holdValid_d = holdValid_q;
        holdData_d  = holdData_q;
        regWe_d     = 1'b0;
        regAddr_d   = regAddr_q;
        regData_d   = regData_q;
        overrun_d   = overrun_q;

        // An ack retires the current beat; a held byte moves up without a bubble.
        if (ack) begin
            memReq_d = 1'b0;
            if (holdValid_q) begin
                memReq_d    = 1'b1;
                memAddr_d   = addr_q;
                memData_d   = holdData_q;
                addr_d      = addr_q + AW'(1);
                holdValid_d = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (byteOk) begin
                    byteCnt_d = '0;
                    case (byteIn_i)
                        8'h01:   state_d = REGA;
                        8'h02:   begin state_d = ADDR; isFill_d = 1'b0; end
                        8'h03:   begin state_d = ADDR; isFill_d = 1'b1; end
                        default: state_d = SKIP;
                    endcase
                end
            end
            FILL: begin
                if (byteOk) overrun_d = 1'b1;
                if (ack) begin
                    if (cnt_q != 16'd0) begin
                        memReq_d  = 1'b1;
                        memAddr_d = addr_q;
                        memData_d = fillVal_q;
                        addr_d    = addr_q + AW'(1);
                        cnt_d     = cnt_q - 16'd1;
                    end else begin
                        state_d = frameActive_i ? SKIP : IDLE;
                    end
                end
            end
            DRAIN: begin
                if (!memReq_q && !holdValid_q) state_d = IDLE;
            end
            default: begin
                if (!frameActive_i) begin
                    state_d = DRAIN;
                end else if (byteValid_i) begin
                    case (state_q)
                        REGA: begin
                            regAddr_d = byteIn_i;
                            state_d   = REGD;
                        end
                        REGD: begin
                            regData_d = byteIn_i;
                            regWe_d   = 1'b1;
                            state_d   = SKIP;
                        end
                        ADDR: begin
                            addr_d    = shifted[AW-1:0];
                            byteCnt_d = byteCnt_q + 2'd1;
                            if (byteCnt_q == 2'd2) begin
                                byteCnt_d = '0;
                                state_d   = isFill_q ? CNT : WDATA;
                            end
                        end
                        CNT: begin
                            cnt_d     = {cnt_q[7:0], byteIn_i};
                            byteCnt_d = byteCnt_q + 2'd1;
                            if (byteCnt_q == 2'd1) begin
                                byteCnt_d = '0;
                                state_d   = VAL;
                            end
                        end
                        VAL: begin
                            fillVal_d = byteIn_i;
                            if (cnt_q == 16'd0) begin
                                state_d = SKIP;
                            end else begin
                                memReq_d  = 1'b1;
                                memAddr_d = addr_q;
                                memData_d = byteIn_i;
                                addr_d    = addr_q + AW'(1);
                                cnt_d     = cnt_q - 16'd1;
                                state_d   = FILL;
                            end
                        end
                        WDATA: begin
                            if (!memReq_d) begin
                                memReq_d  = 1'b1;
                                memAddr_d = addr_d;
                                memData_d = byteIn_i;
                                addr_d    = addr_d + AW'(1);
                            end else if (!holdValid_d) begin
                                holdValid_d = 1'b1;
                                holdData_d  = byteIn_i;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    assign memReq_o  = memReq_q;
    assign memAddr_o = memAddr_q;
    assign memData_o = memData_q;
    assign regWe_o   = regWe_q;
    assign regAddr_o = regAddr_q;
    assign regData_o = regData_q;
    assign busy_o    = (state_q != IDLE) || memReq_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: stimulus pushes expected writes into queues,
// a negedge monitor pops and compares them as the DUT completes each write.
module tb_spi_cmd_ctrl;

    localparam int AW = 17;

    logic          clk;
    logic          rstN;
    logic          byteValid;
    logic [7:0]    byteIn;
    logic          frameActive;
    logic          memReq;
    logic [AW-1:0] memAddr;
    logic [7:0]    memData;
    logic          memAck;
    logic          regWe;
    logic [7:0]    regAddr;
    logic [7:0]    regData;
    logic          busy;
    logic          overrun;

    int compared   = 0;
    int mismatched = 0;

    logic [AW+7:0] memQ[$];
    logic [15:0]   regQ[$];

    spi_cmd_ctrl #(.AW(AW)) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .byteValid_i   (byteValid),
        .byteIn_i      (byteIn),
        .frameActive_i (frameActive),
        .memReq_o      (memReq),
        .memAddr_o     (memAddr),
        .memData_o     (memData),
        .memAck_i      (memAck),
        .regWe_o       (regWe),
        .regAddr_o     (regAddr),
        .regData_o     (regData),
        .busy_o        (busy),
        .overrun_o     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One byte strobe; returns 1 time unit after the edge that sampled it.
    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk); #1;
        byteValid = 1'b1;
        byteIn    = b;
        @(posedge clk); #1;
        byteValid = 1'b0;
        byteIn    = 8'h00;
    endtask

    task automatic startFrame();
        @(posedge clk); #1;
        frameActive = 1'b1;
    endtask

    task automatic endFrame();
        @(posedge clk); #1;
        frameActive = 1'b0;
    endtask

    task automatic stepCycle();
        @(posedge clk); #1;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            stepCycle();
            n++;
        end
        checkOutput(name, busy, 1'b0);
    endtask

    // Monitor: every completed handshake must match the head of its queue.
    always @(negedge clk) begin
        if (rstN) begin
            if (memReq && memAck) begin
                checkOutput("memWriteExpected", memQ.size() != 0, 1'b1);
                if (memQ.size() != 0) begin
                    logic [AW+7:0] e;
                    e = memQ.pop_front();
                    checkOutput("memAddr", memAddr, e[AW+7:8]);
                    checkOutput("memData", memData, e[7:0]);
                end
            end
            if (regWe) begin
                checkOutput("regWriteExpected", regQ.size() != 0, 1'b1);
                if (regQ.size() != 0) begin
                    logic [15:0] r;
                    r = regQ.pop_front();
                    checkOutput("regAddr", regAddr, r[15:8]);
                    checkOutput("regData", regData, r[7:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN        = 1'b0;
        byteValid   = 1'b0;
        byteIn      = 8'h00;
        frameActive = 1'b0;
        memAck      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetMemReq", memReq, 1'b0);
        checkOutput("resetBusy", busy, 1'b0);
        checkOutput("resetOverrun", overrun, 1'b0);
        checkOutput("resetRegWe", regWe, 1'b0);
        rstN = 1'b1;
        stepCycle();

        // WRITE_REG 01 3A C5
        $display("[TB] write register");
        regQ.push_back(16'h3AC5);
        startFrame();
        applyStimulus(8'h01);
        checkOutput("busyAfterOpcode", busy, 1'b1);
        applyStimulus(8'h3A);
        applyStimulus(8'hC5);
        checkOutput("regWePulse", regWe, 1'b1);
        stepCycle();
        checkOutput("regWeOneCycle", regWe, 1'b0);
        endFrame();
        waitIdle("idleAfterReg");

        // Truncated WRITE_REG: no strobe may appear
        startFrame();
        applyStimulus(8'h01);
        applyStimulus(8'h3A);
        endFrame();
        waitIdle("idleAfterCutReg");

        // WRITE_MEM with address wrap, ack tied high
        $display("[TB] write memory with wrap");
        memAck = 1'b1;
        memQ.push_back({17'h1FFFF, 8'hAA});
        memQ.push_back({17'h00000, 8'hBB});
        startFrame();
        applyStimulus(8'h02);
        applyStimulus(8'h01);
        applyStimulus(8'hFF);
        applyStimulus(8'hFF);
        applyStimulus(8'hAA);
        checkOutput("memReqAfterAA", memReq, 1'b1);
        applyStimulus(8'hBB);
        checkOutput("memReqAfterBB", memReq, 1'b1);
        endFrame();
        waitIdle("idleAfterWrap");

        // Backpressure: third byte dropped
        $display("[TB] backpressure");
        memAck = 1'b0;
        memQ.push_back({17'h00100, 8'h11});
        memQ.push_back({17'h00101, 8'h22});
        startFrame();
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'h11);
        checkOutput("bpReqUp", memReq, 1'b1);
        applyStimulus(8'h22);
        checkOutput("bpNoOverrunYet", overrun, 1'b0);
        applyStimulus(8'h33);
        checkOutput("bpOverrun", overrun, 1'b1);
        stepCycle();
        checkOutput("bpReqHeld", memReq, 1'b1);
        checkOutput("bpAddrHeld", memAddr, 17'h00100);
        checkOutput("bpDataHeld", memData, 8'h11);
        memAck = 1'b1;
        endFrame();
        waitIdle("idleAfterBp");
        checkOutput("overrunSticky", overrun, 1'b1);

        // FILL of 3 at 0x10, frame drops right after VAL
        $display("[TB] fill");
        memQ.push_back({17'h00010, 8'h5A});
        memQ.push_back({17'h00011, 8'h5A});
        memQ.push_back({17'h00012, 8'h5A});
        startFrame();
        applyStimulus(8'h03);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h10);
        applyStimulus(8'h00);
        applyStimulus(8'h03);
        applyStimulus(8'h5A);
        frameActive = 1'b0;
        checkOutput("fillAddr0", memAddr, 17'h00010);
        stepCycle();
        checkOutput("fillAddr1", memAddr, 17'h00011);
        stepCycle();
        checkOutput("fillAddr2", memAddr, 17'h00012);
        checkOutput("fillReq2", memReq, 1'b1);
        stepCycle();
        checkOutput("fillDone", memReq, 1'b0);
        checkOutput("fillBusyLow", busy, 1'b0);

        // FILL with a zero count
        startFrame();
        applyStimulus(8'h03);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h20);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h77);
        checkOutput("zeroFillNoReq", memReq, 1'b0);
        stepCycle();
        checkOutput("zeroFillNoReqLater", memReq, 1'b0);
        endFrame();
        waitIdle("idleAfterZeroFill");

        // Unknown opcode swallows the rest of the frame
        $display("[TB] unknown opcode");
        startFrame();
        applyStimulus(8'h7F);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'hAA);
        checkOutput("skipNoReq", memReq, 1'b0);
        endFrame();
        waitIdle("idleAfterSkip");
        memQ.push_back({17'h00000, 8'hAA});
        startFrame();
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'hAA);
        endFrame();
        waitIdle("idleAfterWriteZero");

        // Reset in the middle of a stalled fill
        $display("[TB] reset mid-fill");
        memAck = 1'b0;
        startFrame();
        applyStimulus(8'h03);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h10);
        applyStimulus(8'h99);
        endFrame();
        checkOutput("fillStalledReq", memReq, 1'b1);
        rstN = 1'b0;
        #1;
        checkOutput("rstMemReq", memReq, 1'b0);
        checkOutput("rstMemAddr", memAddr, 17'h0);
        checkOutput("rstMemData", memData, 8'h0);
        checkOutput("rstRegAddr", regAddr, 8'h0);
        checkOutput("rstRegData", regData, 8'h0);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstOverrun", overrun, 1'b0);
        memAck = 1'b1;
        repeat (2) stepCycle();
        rstN = 1'b1;
        repeat (5) stepCycle();
        checkOutput("postRstNoReq", memReq, 1'b0);
        checkOutput("postRstIdle", busy, 1'b0);

        checkOutput("memQueueDrained", memQ.size(), 0);
        checkOutput("regQueueDrained", regQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
